// File: rtl/branch_pkg.sv
// Shared opcode and FSM encodings for the branch resolution stage and its
// condition evaluator.
package branch_pkg;

    localparam logic [2:0] BR  = 3'b000;
    localparam logic [2:0] BMI = 3'b001;
    localparam logic [2:0] BPL = 3'b010;
    localparam logic [2:0] BZ  = 3'b011;
    localparam logic [2:0] BNZ = 3'b100;
    localparam logic [2:0] BEQ = 3'b101;
    localparam logic [2:0] BLT = 3'b110;
    localparam logic [2:0] NOP = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Purely combinational branch condition evaluator. A code with no defined
// condition evaluates to not-taken.
module branch_cond
    import branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              cond
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_val[DATA_W-1];
    assign rs_zero = (rs_val == '0);

    always_comb begin
        // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
        cond = 1'b0;
        case (br_op)
            BR:      cond = 1'b1;
            BMI:     cond = rs_neg;
            BPL:     cond = !rs_neg && !rs_zero;
            BZ:      cond = rs_zero;
            BNZ:     cond = !rs_zero;
            BEQ:     cond = (rs_val == rt_val);
            BLT:     cond = ($signed(rs_val) < $signed(rt_val));
            NOP:     cond = 1'b0;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: registered outcome/target, multi-cycle flush with
// issue back-pressure, and saturating resolved/taken performance counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] offset,
    output logic              out_valid,
    output logic              taken,
    output logic [ADDR_W-1:0] target,
    output logic              flush,
    output logic [CNT_W-1:0]  resolved_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              out_valid_q;
    logic              taken_q;
    logic [ADDR_W-1:0] target_q;
    logic [CNT_W-1:0]  resolved_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic cond;
    logic accept;

    branch_cond #(
        .DATA_W (DATA_W)
    ) u_cond (
        .br_op  (br_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cond   (cond)
    );

    // Reset overrides a simultaneous handshake, so it is folded into accept.
    assign accept = in_valid && in_ready && !rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (accept && cond) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE);
        flush    = (state_q == FLUSH);
    end

    // Result registers; taken/target hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                taken_q  <= cond;
                target_q <= pc + offset;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_q  <= '0;
            taken_cnt_q <= '0;
        end else if (accept) begin
            if (resolved_q != '1) begin
                resolved_q <= resolved_q + 1'b1;
            end
            if (cond && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign taken          = taken_q;
    assign target         = target_q;
    assign resolved_count = resolved_q;
    assign taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver queues expected
// results at issue time, an independent monitor checks each out_valid pulse.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        br_op = NOP;
    logic [DATA_W-1:0] rs_val = '0;
    logic [DATA_W-1:0] rt_val = '0;
    logic [ADDR_W-1:0] pc = '0;
    logic [ADDR_W-1:0] offset = '0;
    logic              out_valid;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              flush;
    logic [CNT_W-1:0]  resolved_count;
    logic [CNT_W-1:0]  taken_count;

    branch_resolve_unit #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .br_op          (br_op),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .pc             (pc),
        .offset         (offset),
        .out_valid      (out_valid),
        .taken          (taken),
        .target         (target),
        .flush          (flush),
        .resolved_count (resolved_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic [31:0] tgt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every out_valid pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            check("missing_out_valid", 32'd0, 32'd1);
            void'(q.pop_front());
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("out_valid_latency", cyc, e.cyc);
                check("taken", {31'd0, taken}, {31'd0, e.tk});
                check("target", target, e.tgt);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pcv, input logic [31:0] off);
        br_op = op; rs_val = rs; rt_val = rt; pc = pcv; offset = off; in_valid = 1'b1;
    endtask

    // Present one instruction, wait (bounded) for in_ready, return #1 after accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pcv, input logic [31:0] off,
                         input logic exp_tk, input logic [31:0] exp_tgt);
        int n = 0;
        @(negedge clk);
        drive(op, rs, rt, pcv, off);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            q.push_back('{exp_tk, exp_tgt, cyc + 1});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_taken", {31'd0, taken}, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_resolved", {28'd0, resolved_count}, 32'd0);
        check("rst_taken_cnt", {28'd0, taken_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // One case per opcode family, taken and not-taken.
        issue(BPL, 32'h0,        32'h0,        32'h1000, 32'h4,        1'b0, 32'h1004);
        issue(BPL, 32'h5,        32'h0,        32'h1000, 32'h20,       1'b1, 32'h1020);
        issue(BMI, 32'h80000000, 32'h0,        32'h2000, 32'h10,       1'b1, 32'h2010);
        issue(BMI, 32'h7FFFFFFF, 32'h0,        32'h2000, 32'h10,       1'b0, 32'h2010);
        issue(BLT, 32'hFFFFFFFF, 32'h1,        32'h3000, 32'hFFFFFF00, 1'b1, 32'h2F00);
        issue(BLT, 32'h1,        32'hFFFFFFFF, 32'h3000, 32'h8,        1'b0, 32'h3008);
        issue(BEQ, 32'h1234,     32'h1234,     32'h4000, 32'h40,       1'b1, 32'h4040);
        issue(NOP, 32'h0,        32'h0,        32'h5000, 32'h4,        1'b0, 32'h5004);
        issue(BZ,  32'h0,        32'h0,        32'h6000, 32'h100,      1'b1, 32'h6100);
        issue(BNZ, 32'h3,        32'h0,        32'h7000, 32'h8,        1'b1, 32'h7008);
        repeat (4) @(negedge clk);
        check("opcodes_resolved", {28'd0, resolved_count}, 32'd10);
        check("opcodes_taken_cnt", {28'd0, taken_count}, 32'd6);

        // Taken BR: flush window, back-pressure, instruction held during flush.
        do_reset();
        @(negedge clk);
        drive(BR, 32'h0, 32'h0, 32'h100, 32'hFFFFFFF0);
        check("br_ready_before", {31'd0, in_ready}, 32'd1);
        q.push_back('{1'b1, 32'hF0, cyc + 1});
        @(posedge clk);
        #1 drive(BZ, 32'h1, 32'h0, 32'h200, 32'h10);
        for (int i = 1; i <= FLUSH_CYCLES; i++) begin
            @(negedge clk);
            check("flush_window", {31'd0, flush}, 32'd1);
            check("ready_in_flush", {31'd0, in_ready}, 32'd0);
            check("resolved_in_flush", {28'd0, resolved_count}, 32'd1);
        end
        @(negedge clk);
        check("flush_ends", {31'd0, flush}, 32'd0);
        check("ready_after_flush", {31'd0, in_ready}, 32'd1);
        check("resolved_before_held", {28'd0, resolved_count}, 32'd1);
        q.push_back('{1'b0, 32'h210, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("resolved_after_held", {28'd0, resolved_count}, 32'd2);
        check("taken_cnt_after_held", {28'd0, taken_count}, 32'd1);

        // Target wrap-around.
        issue(BZ, 32'h1, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b0, 32'h4);

        // Ten back-to-back not-taken branches.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            issue(BZ, 32'h1, 32'h0, 32'h8000 + 32'(i * 4), 32'h4, 1'b0, 32'h8004 + 32'(i * 4));
            check("bz_no_flush", {31'd0, flush}, 32'd0);
        end
        repeat (2) @(negedge clk);
        check("bz_resolved", {28'd0, resolved_count}, 32'd10);
        check("bz_taken_cnt", {28'd0, taken_count}, 32'd0);

        // Saturation of both 4-bit counters.
        do_reset();
        repeat (20) issue(BR, 32'h0, 32'h0, 32'h10, 32'h10, 1'b1, 32'h20);
        repeat (4) @(negedge clk);
        check("sat_resolved", {28'd0, resolved_count}, 32'd15);
        check("sat_taken_cnt", {28'd0, taken_count}, 32'd15);

        // Reset mid-flush, then reset colliding with in_valid.
        issue(BR, 32'h0, 32'h0, 32'h300, 32'h30, 1'b1, 32'h330);
        @(negedge clk);
        check("midflush_flush_high", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midflush_flush_drop", {31'd0, flush}, 32'd0);
        check("midflush_resolved", {28'd0, resolved_count}, 32'd0);
        check("midflush_taken_cnt", {28'd0, taken_count}, 32'd0);
        check("midflush_ready", {31'd0, in_ready}, 32'd1);
        drive(BR, 32'h0, 32'h0, 32'h400, 32'h4);
        @(negedge clk);
        check("rst_wins_resolved", {28'd0, resolved_count}, 32'd0);
        check("rst_wins_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_resolved", {28'd0, resolved_count}, 32'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch resolution stage for the RISC core.
- Evaluates the branch condition on register operands and computes the target, both registered.
- Generates a multi-cycle pipeline flush on a taken branch and back-pressures issue while the flush is active.
- Keeps saturating resolved/taken counters for performance inspection.
- Sits between operand read and PC-select/fetch control.

Parameters:
DATA_W, 32, width of rs/rt operands
ADDR_W, 32, width of pc, offset, target
FLUSH_CYCLES, 2, cycles flush stays high after a taken branch; legal range >= 1
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  branch instruction presented
in_ready  output  1  unit can accept; equals (state == IDLE)
br_op  input  3  branch opcode (see Behaviour)
rs_val  input  DATA_W  first operand
rt_val  input  DATA_W  second operand (BEQ/BLT only)
pc  input  ADDR_W  PC of the branch instruction
offset  input  ADDR_W  two's-complement branch offset
out_valid  output  1  one-cycle pulse: a result is present
taken  output  1  branch outcome, qualified by out_valid
target  output  ADDR_W  pc + offset, qualified by out_valid
flush  output  1  kill younger instructions
resolved_count  output  CNT_W  number of branches accepted
taken_count  output  CNT_W  number of taken branches

Behaviour:
- Opcodes and conditions:
  - BR=000: always taken.
  - BMI=001: rs[MSB]==1.
  - BPL=010: rs>0 signed, i.e. MSB==0 and rs!=0.
  - BZ=011: rs==0.
  - BNZ=100: rs!=0.
  - BEQ=101: rs==rt.
  - BLT=110: rs<rt signed.
  - NOP=111: never taken.
- Accept: handshake in_valid && in_ready at edge T.
- Latency 1: at T+1 out_valid=1 for exactly one cycle; taken and target are registered.
- target = (pc + offset) mod 2^ADDR_W. Wrap-around is silent and target is computed regardless of taken.
- Outside out_valid cycles, taken and target hold their last values.
- FSM states IDLE and FLUSH, with down-counter fcnt of width clog2(FLUSH_CYCLES+1):
  - IDLE to FLUSH: on an accepted taken branch. Load fcnt=FLUSH_CYCLES-1.
  - FLUSH: flush=1 and in_ready=0. Decrement fcnt each cycle; go to IDLE when fcnt==0.
  - Net effect: flush is high on cycles T+1 .. T+FLUSH_CYCLES.
  - The next accept is possible at edge T+FLUSH_CYCLES+1.
- Not-taken branches:
  - Stay in IDLE with flush=0.
  - Back-to-back accepts every cycle are allowed, giving one out_valid per accept.
- in_valid while in FLUSH is ignored. The source must hold the instruction, or drop it if it was killed.
- Counters, updated at T+1 together with out_valid:
  - resolved_count +1 per accept.
  - taken_count +1 per taken accept.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous):
  - State and fcnt: state=IDLE, fcnt=0.
  - Outputs: out_valid=0, taken=0, target=0, flush=0, both counters=0.
  - While rst is high, inputs are ignored and nothing is accepted.
- Reset mid-flush: flush drops at the edge where rst is sampled. in_ready=1 on the cycle after rst deasserts.
- rst and in_valid in the same cycle: reset wins and the instruction is not counted.

Decomposition:
- Package branch_pkg:
  - 3-bit opcode localparams BR, BMI, BPL, BZ, BNZ, BEQ, BLT, NOP.
  - State encoding IDLE and FLUSH.
- Sub-module branch_cond #(DATA_W):
  - Combinational condition evaluator (br_op, rs_val, rt_val -> cond).
  - Unknown codes give 0.
- Parent holds FSM, registers, adder and counters.

Test Plan:
- Directed branch cases, one per opcode, DATA_W=32:
  - BPL with rs=0 -> taken=0.
  - BPL with rs=5 -> taken=1.
  - BMI with rs=0x80000000 -> taken=1.
  - BLT rs=-1, rt=1 -> taken=1 (signed).
  - BEQ rs=rt=0x1234 -> taken=1.
  - NOP -> taken=0.
  - Every case: out_valid exactly one cycle after accept.
- Taken BR with pc=0x100, offset=0xFFFFFFF0 -> target=0xF0 at T+1.
  - flush high at T+1 and T+2 (FLUSH_CYCLES=2), in_ready low at T+1 and T+2.
  - Next accept at T+3.
- Wrap: pc=0xFFFFFFFC, offset=8 -> target=0x4. 10 consecutive not-taken BZ (rs=1) -> 10 out_valid pulses, flush never high, resolved_count=10, taken_count=0.
- Saturation with CNT_W=4: 20 taken BR -> both counters stick at 15.
- Reset mid-flush: assert rst at T+1 of a taken branch -> next cycle flush=0, counters=0, state IDLE, in_ready=1 after rst drops.
- Offered during flush: in_valid held high through the FLUSH window -> not accepted, resolved_count unchanged until edge T+FLUSH_CYCLES+1.
